idma_legalizer_rw_axi_mc: RTL and testbench
===========================================

// Module: idma_legalizer_rw_axi_mc
// PURPOSE
//  Multi-channel, parametrised 1D-transfer legalizer for the iDMA AXI backend.
//  - Arbitrates NumChannels 1D requests round-robin and splits the granted transfer into AXI INCR bursts.
//  - Bursts never cross a PageSize boundary and never exceed MaxBeats beats.
//  - Emits buffered AR and AW burst descriptors, read/write coupled or decoupled per request.
//  - Sits between the midend/frontend request arbiter and the AXI read/write managers of the backend.
// PARAMETERS
//  NumChannels  2     number of request channels (>=1)
//  DataWidth    64    bus data width in bits, power of two >=16; StrbWidth=DataWidth/8, OffsetWidth=log2(StrbWidth)
//  AddrWidth    32    byte address width
//  LenWidth     32    transfer length width in bytes
//  IdWidth      4     AXI ID width
//  MaxBeats     256   max beats per burst, power of two, 1..256
//  PageSize     4096  boundary in bytes, power of two >= StrbWidth
// PORTS
//  clk_i            in   1                    clock
//  rst_ni           in   1                    asynchronous reset, active low
//  req_valid_i      in   NumChannels          per-channel request valid
//  req_ready_o      out  NumChannels          per-channel request ready (one-hot or zero)
//  req_src_addr_i   in   NumChannels*AddrWidth  source byte address, channel c at slice c
//  req_dst_addr_i   in   NumChannels*AddrWidth  destination byte address
//  req_length_i     in   NumChannels*LenWidth   length in bytes
//  req_id_i         in   NumChannels*IdWidth    AXI ID for all bursts of the transfer
//  req_decouple_i   in   NumChannels          1: R/W legalized independently
//  ar_valid_o/ar_ready_i  out/in 1            AR descriptor handshake
//  ar_addr_o        out  AddrWidth            beat-aligned read address
//  ar_len_o         out  8                    AXI len (beats-1)
//  ar_id_o          out  IdWidth              AXI ID
//  ar_offset_o      out  OffsetWidth          first-beat byte offset
//  ar_tailer_o      out  OffsetWidth          (bytes+offset) mod StrbWidth
//  aw_valid_o/aw_ready_i  out/in 1            AW descriptor handshake
//  aw_addr_o, aw_len_o, aw_id_o, aw_offset_o, aw_tailer_o  out   as AR, for write
//  aw_last_o        out  1                    last write burst of the transfer
//  aw_chan_o        out  log2(NumChannels)    originating channel (width 1 if NumChannels==1)
//  kill_i           in   1                    abort active transfer, drop buffered descriptors
//  busy_o           out  1                    transfer active or descriptor pending
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; RR pointer=0.
//  FSM IDLE
//  - Grant = first valid channel at or after the RR pointer (wrapping); req_ready_o[grant]=1 combinationally.
//  - No grant while kill_i=1 or while either output slot is still valid.
//  - On handshake: latch src/dst/len/id/decouple; RR pointer=grant+1 mod NumChannels.
//  - Length 0: accept, emit no bursts, stay IDLE.
//  - Length >0: go to BURST.
//  FSM BURST, per side (R uses src, W uses dst)
//  - Limit L = MaxBytes - (addr mod MaxBytes), where MaxBytes = min(PageSize, MaxBeats*StrbWidth).
//  - Coupled: both sides use min(L_r, L_w). Decoupled: each side uses its own L.
//  - bytes = min(remaining, limit); len = (bytes + offset - 1) >> OffsetWidth; addr advances by bytes.
//  - Arithmetic uses log2(MaxBytes)+1 bits, with no overflow at MaxBytes.
//  Output slots (one register per side)
//  - A slot loads when empty or accepted in the same cycle (ready&valid).
//  - Coupled: both sides load in the same cycle only.
//  - Decoupled: each side loads independently.
//  - Valid holds and all fields stay stable until ready.
//  - aw_last_o=1 on the final write burst.
//  - First descriptor is valid on the 2nd rising edge after the request handshake.
//  - Sustained throughput: 1 burst/cycle/side when ready held high.
//  - BURST -> IDLE once both sides have loaded their final burst.
//  - The next grant waits until both slots are drained.
//  kill_i (sync)
//  - Clears both slots and the remaining lengths; FSM -> IDLE next cycle.
//  - Dominates a same-cycle ready; no request is granted that cycle.
//  Reset mid-operation discards everything; no partial descriptor appears after reset release.
//  busy_o = (FSM!=IDLE) | ar_valid_o | aw_valid_o.
//  Burst type is always INCR, size=OffsetWidth.
// TESTING (DataWidth=64, MaxBeats=256, PageSize=4096, NumChannels=2)
//  1 Coupled request: src 0x0FF8, dst 0x2000, len 16.
//    -> AR {0x0FF8,len0,off0} then {0x1000,len0}; AW {0x2000,len0} then {0x2008,len0,last}.
//  2 Same request with decouple=1.
//    -> AR as in scenario 1; single AW {0x2000,len1,last}.
//  3 src 0, dst 0x10000, len 4096, coupled.
//    -> AR/AW bursts at +0x000 and +0x800, each len 255; last on the 2nd AW only.
//  4 src 0x3, dst 0x5, len 10.
//    -> AR len1 off3 tailer5; AW len1 off5 tailer7; single burst each.
//  5 Both channels valid back-to-back (len 8).
//    -> grant order ch0,ch1,ch0,ch1; aw_chan_o matches.
//    -> Length-0 request accepted with no AR/AW.
//  6 Hold aw_ready_i=0 and assert kill_i mid-transfer.
//    -> ar/aw_valid_o=0 next cycle, busy_o=0, FSM IDLE.
//    -> Asserting rst_ni=0 mid-burst gives the same response.

Source files
------------

// File: rtl/idma_legalizer_rw_axi_mc_if.sv
// Request, AR/AW descriptor and control signals of the multi-channel AXI legalizer.
interface idma_legalizer_rw_axi_mc_if #(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned LenWidth    = 32,
  parameter int unsigned IdWidth     = 4
);
  localparam int unsigned OffsetWidth = $clog2(DataWidth / 8);
  localparam int unsigned ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic [NumChannels-1:0]           req_valid_i;
  logic [NumChannels-1:0]           req_ready_o;
  logic [NumChannels*AddrWidth-1:0] req_src_addr_i;
  logic [NumChannels*AddrWidth-1:0] req_dst_addr_i;
  logic [NumChannels*LenWidth-1:0]  req_length_i;
  logic [NumChannels*IdWidth-1:0]   req_id_i;
  logic [NumChannels-1:0]           req_decouple_i;

  logic                   ar_valid_o;
  logic                   ar_ready_i;
  logic [AddrWidth-1:0]   ar_addr_o;
  logic [7:0]             ar_len_o;
  logic [IdWidth-1:0]     ar_id_o;
  logic [OffsetWidth-1:0] ar_offset_o;
  logic [OffsetWidth-1:0] ar_tailer_o;

  logic                   aw_valid_o;
  logic                   aw_ready_i;
  logic [AddrWidth-1:0]   aw_addr_o;
  logic [7:0]             aw_len_o;
  logic [IdWidth-1:0]     aw_id_o;
  logic [OffsetWidth-1:0] aw_offset_o;
  logic [OffsetWidth-1:0] aw_tailer_o;
  logic                   aw_last_o;
  logic [ChanWidth-1:0]   aw_chan_o;

  logic kill_i;
  logic busy_o;

  // Legalizer side
  modport slave (
    input  req_valid_i, req_src_addr_i, req_dst_addr_i, req_length_i, req_id_i, req_decouple_i,
    output req_ready_o,
    output ar_valid_o, ar_addr_o, ar_len_o, ar_id_o, ar_offset_o, ar_tailer_o,
    input  ar_ready_i,
    output aw_valid_o, aw_addr_o, aw_len_o, aw_id_o, aw_offset_o, aw_tailer_o, aw_last_o,
    output aw_chan_o,
    input  aw_ready_i,
    input  kill_i,
    output busy_o
  );

  // Requester / manager side
  modport master (
    output req_valid_i, req_src_addr_i, req_dst_addr_i, req_length_i, req_id_i, req_decouple_i,
    input  req_ready_o,
    input  ar_valid_o, ar_addr_o, ar_len_o, ar_id_o, ar_offset_o, ar_tailer_o,
    output ar_ready_i,
    input  aw_valid_o, aw_addr_o, aw_len_o, aw_id_o, aw_offset_o, aw_tailer_o, aw_last_o,
    input  aw_chan_o,
    output aw_ready_i,
    output kill_i,
    input  busy_o
  );
endinterface

// File: rtl/idma_legalizer_rw_axi_mc.sv
// Multi-channel 1D legalizer: round-robin request grant, split into AXI INCR bursts that never
// cross MaxBytes = min(PageSize, MaxBeats*StrbWidth) boundaries, buffered AR/AW descriptor slots.
module idma_legalizer_rw_axi_mc #(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned LenWidth    = 32,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned MaxBeats    = 256,
  parameter int unsigned PageSize    = 4096
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  idma_legalizer_rw_axi_mc_if.slave bus
);
  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);
  localparam int unsigned MaxBytes    = (PageSize < MaxBeats * StrbWidth) ? PageSize
                                                                          : MaxBeats * StrbWidth;
  localparam int unsigned MbWidth     = $clog2(MaxBytes) + 1;
  localparam int unsigned ChanWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;
  typedef logic [MbWidth-1:0]   mb_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [LenWidth-1:0]  len_t;
  typedef logic [OffsetWidth-1:0] off_t;

  state_e                 state_q, state_d;
  logic [ChanWidth-1:0]   rr_q, rr_d, chan_q, chan_d, grant_idx;
  logic                   grant_valid, req_hs;
  logic [NumChannels-1:0] req_ready;
  addr_t                  r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  len_t                   r_rem_q, r_rem_d, w_rem_q, w_rem_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic                   dec_q, dec_d;

  logic               ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d;
  addr_t              ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [7:0]         ar_len_q, ar_len_d, aw_len_q, aw_len_d;
  off_t               ar_off_q, ar_off_d, aw_off_q, aw_off_d;
  off_t               ar_tail_q, ar_tail_d, aw_tail_q, aw_tail_d;
  logic [IdWidth-1:0] ar_id_q, ar_id_d, aw_id_q, aw_id_d;
  logic               aw_last_q, aw_last_d;
  logic [ChanWidth-1:0] aw_chan_q, aw_chan_d;

  mb_t  r_lim, w_lim, r_use, w_use, r_bytes, w_bytes, r_sum, w_sum;
  logic ld_r, ld_w;

  // Bytes left before the next MaxBytes boundary; equals MaxBytes when aligned.
  function automatic mb_t limit(addr_t a);
    return mb_t'(MaxBytes) - mb_t'(a[MbWidth-2:0]);
  endfunction

  function automatic mb_t clip(len_t rem, mb_t lim);
    return (rem < len_t'(lim)) ? mb_t'(rem) : lim;
  endfunction

  // Round-robin search from the pointer; grant only when idle, not killed and both slots drained.
  always_comb begin
    int c;
    c           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < int'(NumChannels); i++) begin
      c = int'(rr_q) + i;
      if (c >= int'(NumChannels)) c = c - int'(NumChannels);
      if (!grant_valid && bus.req_valid_i[c]) begin
        grant_valid = 1'b1;
        grant_idx   = ChanWidth'(c);
      end
    end
    req_hs    = grant_valid && (state_q == StIdle) && !bus.kill_i && !ar_valid_q && !aw_valid_q;
    req_ready = '0;
    if (req_hs) req_ready[grant_idx] = 1'b1;
  end

  // Burst splitting, slot loading and FSM next state.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    chan_d     = chan_q;
    r_addr_d   = r_addr_q;
    w_addr_d   = w_addr_q;
    r_rem_d    = r_rem_q;
    w_rem_d    = w_rem_q;
    id_d       = id_q;
    dec_d      = dec_q;
    ar_valid_d = ar_valid_q & ~bus.ar_ready_i;
    aw_valid_d = aw_valid_q & ~bus.aw_ready_i;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_off_d   = ar_off_q;
    ar_tail_d  = ar_tail_q;
    ar_id_d    = ar_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_off_d   = aw_off_q;
    aw_tail_d  = aw_tail_q;
    aw_id_d    = aw_id_q;
    aw_last_d  = aw_last_q;
    aw_chan_d  = aw_chan_q;
    ld_r       = 1'b0;
    ld_w       = 1'b0;

    r_lim = limit(r_addr_q);
    w_lim = limit(w_addr_q);
    // Coupled transfers share the tighter limit so R and W bursts pair up one-to-one.
    r_use = r_lim;
    w_use = w_lim;
    if (!dec_q) begin
      r_use = (w_lim < r_lim) ? w_lim : r_lim;
      w_use = r_use;
    end
    r_bytes = clip(r_rem_q, r_use);
    w_bytes = clip(w_rem_q, w_use);
    r_sum   = r_bytes + mb_t'(r_addr_q[OffsetWidth-1:0]);
    w_sum   = w_bytes + mb_t'(w_addr_q[OffsetWidth-1:0]);

    case (state_q)
      StIdle: begin
        if (req_hs) begin
          rr_d     = (grant_idx == ChanWidth'(NumChannels - 1)) ? '0 : grant_idx + 1'b1;
          chan_d   = grant_idx;
          r_addr_d = bus.req_src_addr_i[grant_idx*AddrWidth +: AddrWidth];
          w_addr_d = bus.req_dst_addr_i[grant_idx*AddrWidth +: AddrWidth];
          r_rem_d  = bus.req_length_i[grant_idx*LenWidth +: LenWidth];
          w_rem_d  = bus.req_length_i[grant_idx*LenWidth +: LenWidth];
          id_d     = bus.req_id_i[grant_idx*IdWidth +: IdWidth];
          dec_d    = bus.req_decouple_i[grant_idx];
          if (bus.req_length_i[grant_idx*LenWidth +: LenWidth] != '0) state_d = StBurst;
        end
      end
      StBurst: begin
        if (dec_q) begin
          ld_r = (r_rem_q != '0) && (!ar_valid_q || bus.ar_ready_i);
          ld_w = (w_rem_q != '0) && (!aw_valid_q || bus.aw_ready_i);
        end else begin
          ld_r = (r_rem_q != '0) && (w_rem_q != '0) && (!ar_valid_q || bus.ar_ready_i) &&
                 (!aw_valid_q || bus.aw_ready_i);
          ld_w = ld_r;
        end
        if (ld_r) begin
          ar_valid_d = 1'b1;
          ar_addr_d  = {r_addr_q[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
          ar_len_d   = 8'((r_sum - mb_t'(1)) >> OffsetWidth);
          ar_off_d   = r_addr_q[OffsetWidth-1:0];
          ar_tail_d  = r_sum[OffsetWidth-1:0];
          ar_id_d    = id_q;
          r_addr_d   = r_addr_q + addr_t'(r_bytes);
          r_rem_d    = r_rem_q - len_t'(r_bytes);
        end
        if (ld_w) begin
          aw_valid_d = 1'b1;
          aw_addr_d  = {w_addr_q[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
          aw_len_d   = 8'((w_sum - mb_t'(1)) >> OffsetWidth);
          aw_off_d   = w_addr_q[OffsetWidth-1:0];
          aw_tail_d  = w_sum[OffsetWidth-1:0];
          aw_id_d    = id_q;
          aw_last_d  = (w_rem_q == len_t'(w_bytes));
          aw_chan_d  = chan_q;
          w_addr_d   = w_addr_q + addr_t'(w_bytes);
          w_rem_d    = w_rem_q - len_t'(w_bytes);
        end
        if (r_rem_d == '0 && w_rem_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Kill overrides everything, including a same-cycle descriptor acceptance.
    if (bus.kill_i) begin
      ar_valid_d = 1'b0;
      aw_valid_d = 1'b0;
      r_rem_d    = '0;
      w_rem_d    = '0;
      state_d    = StIdle;
    end
  end

  // State and slot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      chan_q     <= '0;
      r_addr_q   <= '0;
      w_addr_q   <= '0;
      r_rem_q    <= '0;
      w_rem_q    <= '0;
      id_q       <= '0;
      dec_q      <= 1'b0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_off_q   <= '0;
      ar_tail_q  <= '0;
      ar_id_q    <= '0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_off_q   <= '0;
      aw_tail_q  <= '0;
      aw_id_q    <= '0;
      aw_last_q  <= 1'b0;
      aw_chan_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      chan_q     <= chan_d;
      r_addr_q   <= r_addr_d;
      w_addr_q   <= w_addr_d;
      r_rem_q    <= r_rem_d;
      w_rem_q    <= w_rem_d;
      id_q       <= id_d;
      dec_q      <= dec_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_off_q   <= ar_off_d;
      ar_tail_q  <= ar_tail_d;
      ar_id_q    <= ar_id_d;
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_off_q   <= aw_off_d;
      aw_tail_q  <= aw_tail_d;
      aw_id_q    <= aw_id_d;
      aw_last_q  <= aw_last_d;
      aw_chan_q  <= aw_chan_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.ar_valid_o  = ar_valid_q;
  assign bus.ar_addr_o   = ar_addr_q;
  assign bus.ar_len_o    = ar_len_q;
  assign bus.ar_id_o     = ar_id_q;
  assign bus.ar_offset_o = ar_off_q;
  assign bus.ar_tailer_o = ar_tail_q;
  assign bus.aw_valid_o  = aw_valid_q;
  assign bus.aw_addr_o   = aw_addr_q;
  assign bus.aw_len_o    = aw_len_q;
  assign bus.aw_id_o     = aw_id_q;
  assign bus.aw_offset_o = aw_off_q;
  assign bus.aw_tailer_o = aw_tail_q;
  assign bus.aw_last_o   = aw_last_q;
  assign bus.aw_chan_o   = aw_chan_q;
  assign bus.busy_o      = (state_q != StIdle) | ar_valid_q | aw_valid_q;
endmodule

// File: tb/tb_idma_legalizer_rw_axi_mc.sv
// Self-checking bench: directed scenarios plus random transfers against a burst-list model.
module tb_idma_legalizer_rw_axi_mc;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  off;
    logic [2:0]  tail;
    logic [3:0]  id;
    logic        last;
    logic        chan;
  } desc_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] src_v[2], dst_v[2], len_v[2];
  logic [3:0]  id_v[2];
  logic        dec_v[2];
  logic [1:0]  req_valid_v;
  desc_t       exp_ar[$], exp_aw[$];
  int          grant_log[$];
  int          ar_cnt = 0, aw_cnt = 0;
  bit          rand_ready, stab_en;
  logic        ar_rdy_val, aw_rdy_val;
  logic        ar_hold_p, aw_hold_p;
  logic [63:0] ar_prev, aw_prev;

  idma_legalizer_rw_axi_mc_if bus ();

  idma_legalizer_rw_axi_mc dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 2; c++) begin
      bus.req_src_addr_i[c*32 +: 32] = src_v[c];
      bus.req_dst_addr_i[c*32 +: 32] = dst_v[c];
      bus.req_length_i[c*32 +: 32]   = len_v[c];
      bus.req_id_i[c*4 +: 4]         = id_v[c];
      bus.req_decouple_i[c]          = dec_v[c];
    end
    bus.req_valid_i = req_valid_v;
  endtask

  // Expected descriptor for a burst of b bytes starting at byte address a.
  function automatic desc_t mk(logic [31:0] a, longint b, logic [3:0] id, logic last, logic chan);
    desc_t  d;
    longint off;
    off    = longint'(a) % 8;
    d.addr = a - 32'(off);
    d.len  = 8'((b + off - 1) / 8);
    d.off  = 3'(off);
    d.tail = 3'((b + off) % 8);
    d.id   = id;
    d.last = last;
    d.chan = chan;
    return d;
  endfunction

  // Split a transfer into bursts: boundary 2048 B = min(4096 page, 256 beats * 8 B).
  task automatic model(int c);
    longint      mb = 2048;
    logic [31:0] s, d;
    longint      rs, rw, lr, lw, b;
    s  = src_v[c];
    d  = dst_v[c];
    rs = longint'(len_v[c]);
    rw = rs;
    if (!dec_v[c]) begin
      while (rs > 0) begin
        lr = mb - longint'(s) % mb;
        lw = mb - longint'(d) % mb;
        b  = rs;
        if (lr < b) b = lr;
        if (lw < b) b = lw;
        exp_ar.push_back(mk(s, b, id_v[c], 1'b0, 1'b0));
        exp_aw.push_back(mk(d, b, id_v[c], rs == b, c[0]));
        s  = s + 32'(b);
        d  = d + 32'(b);
        rs = rs - b;
      end
    end else begin
      while (rs > 0) begin
        lr = mb - longint'(s) % mb;
        b  = (lr < rs) ? lr : rs;
        exp_ar.push_back(mk(s, b, id_v[c], 1'b0, 1'b0));
        s  = s + 32'(b);
        rs = rs - b;
      end
      while (rw > 0) begin
        lw = mb - longint'(d) % mb;
        b  = (lw < rw) ? lw : rw;
        exp_aw.push_back(mk(d, b, id_v[c], rw == b, c[0]));
        d  = d + 32'(b);
        rw = rw - b;
      end
    end
  endtask

  // One clock: set readies, observe handshakes due at the coming edge, then step to the negedge.
  task automatic tick();
    int    hs_c;
    desc_t e;
    hs_c = -1;
    if (rand_ready) begin
      bus.ar_ready_i = ($urandom_range(0, 3) != 0);
      bus.aw_ready_i = ($urandom_range(0, 3) != 0);
    end else begin
      bus.ar_ready_i = ar_rdy_val;
      bus.aw_ready_i = aw_rdy_val;
    end
    #1;
    if (stab_en && ar_hold_p)
      chk("ar_hold", {bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_offset_o,
                      bus.ar_tailer_o, bus.ar_id_o}, ar_prev);
    if (stab_en && aw_hold_p)
      chk("aw_hold", {bus.aw_valid_o, bus.aw_addr_o, bus.aw_len_o, bus.aw_offset_o,
                      bus.aw_tailer_o, bus.aw_id_o, bus.aw_last_o, bus.aw_chan_o}, aw_prev);
    for (int c = 0; c < 2; c++)
      if (req_valid_v[c] && bus.req_ready_o[c]) hs_c = c;
    if (hs_c >= 0) begin
      grant_log.push_back(hs_c);
      model(hs_c);
    end
    if (bus.ar_valid_o && bus.ar_ready_i) begin
      ar_cnt++;
      chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
      if (exp_ar.size() != 0) begin
        e = exp_ar.pop_front();
        chk("ar_desc", {bus.ar_addr_o, bus.ar_len_o, bus.ar_offset_o, bus.ar_tailer_o,
                        bus.ar_id_o}, {e.addr, e.len, e.off, e.tail, e.id});
      end
    end
    if (bus.aw_valid_o && bus.aw_ready_i) begin
      aw_cnt++;
      chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
      if (exp_aw.size() != 0) begin
        e = exp_aw.pop_front();
        chk("aw_desc", {bus.aw_addr_o, bus.aw_len_o, bus.aw_offset_o, bus.aw_tailer_o,
                        bus.aw_id_o, bus.aw_last_o, bus.aw_chan_o},
            {e.addr, e.len, e.off, e.tail, e.id, e.last, e.chan});
      end
    end
    ar_hold_p = bus.ar_valid_o && !bus.ar_ready_i;
    aw_hold_p = bus.aw_valid_o && !bus.aw_ready_i;
    ar_prev = {1'b1, bus.ar_addr_o, bus.ar_len_o, bus.ar_offset_o, bus.ar_tailer_o, bus.ar_id_o};
    aw_prev = {1'b1, bus.aw_addr_o, bus.aw_len_o, bus.aw_offset_o, bus.aw_tailer_o, bus.aw_id_o,
               bus.aw_last_o, bus.aw_chan_o};
    @(negedge clk);
    if (hs_c >= 0) begin
      req_valid_v[hs_c] = 1'b0;
      drive();
    end
  endtask

  task automatic set_req(int c, logic [31:0] s, logic [31:0] d, logic [31:0] l, logic [3:0] id,
                         logic dec);
    src_v[c]       = s;
    dst_v[c]       = d;
    len_v[c]       = l;
    id_v[c]        = id;
    dec_v[c]       = dec;
    req_valid_v[c] = 1'b1;
    drive();
  endtask

  task automatic wait_accept(int c);
    for (int i = 0; i < 4000; i++) begin
      if (!req_valid_v[c]) break;
      tick();
    end
    chk("req_accepted", 64'(!req_valid_v[c]), 64'd1);
  endtask

  task automatic do_req(int c, logic [31:0] s, logic [31:0] d, logic [31:0] l, logic [3:0] id,
                        logic dec);
    set_req(c, s, d, l, id, dec);
    wait_accept(c);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      done = (exp_ar.size() == 0) && (exp_aw.size() == 0) && !bus.busy_o && (req_valid_v == 0);
      if (done) break;
      tick();
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    int a0, w0;
    rst_n       = 1'b0;
    req_valid_v = '0;
    for (int c = 0; c < 2; c++) begin
      src_v[c] = '0; dst_v[c] = '0; len_v[c] = '0; id_v[c] = '0; dec_v[c] = 1'b0;
    end
    drive();
    bus.kill_i     = 1'b0;
    bus.ar_ready_i = 1'b0;
    bus.aw_ready_i = 1'b0;
    rand_ready = 1'b0;
    ar_rdy_val = 1'b1;
    aw_rdy_val = 1'b1;
    stab_en    = 1'b1;
    ar_hold_p  = 1'b0;
    aw_hold_p  = 1'b0;
    ar_prev    = '0;
    aw_prev    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {bus.ar_valid_o, bus.aw_valid_o, bus.busy_o, bus.req_ready_o,
                          bus.ar_addr_o, bus.aw_last_o, bus.aw_chan_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: coupled, source crosses a 2 KiB boundary after 8 bytes; check latency too.
    a0 = ar_cnt; w0 = aw_cnt;
    do_req(0, 32'h0FF8, 32'h2000, 32'd16, 4'h1, 1'b0);
    chk("lat_edge1_ar", 64'(bus.ar_valid_o), 64'd0);
    tick();
    chk("lat_edge2_ar", 64'(bus.ar_valid_o), 64'd1);
    chk("lat_edge2_aw", 64'(bus.aw_valid_o), 64'd1);
    drain();
    chk("s1_ar_count", 64'(ar_cnt - a0), 64'd2);
    chk("s1_aw_count", 64'(aw_cnt - w0), 64'd2);

    // Scenario 2: same request decoupled -> single write burst.
    a0 = ar_cnt; w0 = aw_cnt;
    do_req(0, 32'h0FF8, 32'h2000, 32'd16, 4'h2, 1'b1);
    drain();
    chk("s2_ar_count", 64'(ar_cnt - a0), 64'd2);
    chk("s2_aw_count", 64'(aw_cnt - w0), 64'd1);

    // Scenario 3: one page, split at MaxBeats.
    a0 = ar_cnt; w0 = aw_cnt;
    do_req(0, 32'h0, 32'h10000, 32'd4096, 4'h3, 1'b0);
    drain();
    chk("s3_ar_count", 64'(ar_cnt - a0), 64'd2);
    chk("s3_aw_count", 64'(aw_cnt - w0), 64'd2);

    // Scenario 4: unaligned source and destination, on channel 1.
    a0 = ar_cnt; w0 = aw_cnt;
    do_req(1, 32'h3, 32'h5, 32'd10, 4'h4, 1'b0);
    drain();
    chk("s4_ar_count", 64'(ar_cnt - a0), 64'd1);
    chk("s4_aw_count", 64'(aw_cnt - w0), 64'd1);

    // Scenario 5: both channels requesting, grants must alternate from channel 0.
    rand_ready = 1'b1;
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      set_req(0, 32'h100 + 32'(k * 64), 32'h8000 + 32'(k * 64), 32'd8, 4'h5, 1'b0);
      set_req(1, 32'h900 + 32'(k * 64), 32'h9000 + 32'(k * 64), 32'd8, 4'h6, 1'b0);
      for (int i = 0; i < 4000; i++) begin
        if (req_valid_v != 2'b11) break;
        tick();
      end
      req_valid_v = '0;
      drive();
    end
    drain();
    chk("grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) chk("grant_order", 64'(grant_log[k]), 64'(k % 2));

    // Zero-length request: accepted, no descriptors, stays idle.
    a0 = ar_cnt; w0 = aw_cnt;
    do_req(0, 32'h40, 32'h80, 32'd0, 4'h7, 1'b0);
    repeat (3) tick();
    chk("len0_busy", 64'(bus.busy_o), 64'd0);
    chk("len0_no_ar", 64'(ar_cnt - a0), 64'd0);
    chk("len0_no_aw", 64'(aw_cnt - w0), 64'd0);

    // Scenario 6a: stall both managers, then kill.
    rand_ready = 1'b0;
    ar_rdy_val = 1'b0;
    aw_rdy_val = 1'b0;
    do_req(0, 32'h100, 32'h8000, 32'd4096, 4'h8, 1'b0);
    repeat (4) tick();
    chk("kill_pre_valid", {bus.ar_valid_o, bus.aw_valid_o, bus.busy_o}, 64'b111);
    stab_en = 1'b0;
    bus.kill_i = 1'b1;
    tick();
    chk("kill_clears", {bus.ar_valid_o, bus.aw_valid_o, bus.busy_o}, 64'd0);
    exp_ar.delete();
    exp_aw.delete();
    set_req(1, 32'h20, 32'h30, 32'd8, 4'h9, 1'b0);
    #1;
    chk("kill_blocks_grant", 64'(bus.req_ready_o), 64'd0);
    bus.kill_i = 1'b0;
    #1;
    chk("grant_after_kill", 64'(bus.req_ready_o), 64'b10);
    ar_rdy_val = 1'b1;
    aw_rdy_val = 1'b1;
    tick();
    stab_en = 1'b1;
    wait_accept(1);
    drain();

    // Scenario 6b: reset in the middle of a transfer.
    rand_ready = 1'b1;
    do_req(1, 32'h4000, 32'h6000, 32'd4096, 4'hA, 1'b1);
    repeat (3) tick();
    stab_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_clears", {bus.ar_valid_o, bus.aw_valid_o, bus.busy_o}, 64'd0);
    exp_ar.delete();
    exp_aw.delete();
    req_valid_v = '0;
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", {bus.ar_valid_o, bus.aw_valid_o, bus.busy_o}, 64'd0);
    stab_en = 1'b1;

    // Random transfers with random back-pressure.
    for (int n = 0; n < 24; n++) begin
      do_req(int'($urandom_range(0, 1)), $urandom, $urandom, 32'($urandom_range(0, 6000)),
             4'($urandom), 1'($urandom_range(0, 1)));
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
